// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder: sync bytes, command and
// status codes, the parser/responder state enum and the response byte mux.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_REQ = 8'hA5;
  localparam logic [7:0] SYNC_RSP = 8'h5A;

  localparam logic [7:0] CMD_WRITE_LED  = 8'h01;
  localparam logic [7:0] CMD_READ_LED   = 8'h02;
  localparam logic [7:0] CMD_PING       = 8'h03;
  localparam logic [7:0] CMD_READ_STATS = 8'h04;

  typedef enum logic [7:0] {
    STATUS_OK      = 8'h00,
    STATUS_BAD_CHK = 8'h01,
    STATUS_BAD_CMD = 8'h02
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ARG,
    ST_GET_CHK,
    ST_EXEC,
    ST_SEND
  } state_e;

  // Byte idx of the 4-byte response packet: SYNC, STATUS, DATA, CHK.
  function automatic logic [7:0] rsp_byte(input logic [1:0] idx,
                                          input logic [7:0] status,
                                          input logic [7:0] data);
    case (idx)
      2'd0:    rsp_byte = SYNC_RSP;
      2'd1:    rsp_byte = status;
      2'd2:    rsp_byte = data;
      default: rsp_byte = status ^ data;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Parses A5/CMD/ARG/CHK requests from the RX byte stream and returns 5A/STATUS/DATA/CHK.
// Optional feature macro CMD_STATS_EN adds good/error packet counters and READ_STATS.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 270000,
  parameter int unsigned LED_W          = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             err_pulse
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [7:0]       cmd_q, arg_q, chk_q;
  status_e          rsp_status_q, exec_status_d;
  logic [7:0]       rsp_data_q, exec_data_d;
  logic [1:0]       idx_q;
  logic [LED_W-1:0] led_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_err_q;

`ifdef CMD_STATS_EN
  logic [7:0] good_cnt_q, err_cnt_q;
`endif

  // Decode of the latched request, consumed only during EXEC.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    exec_status_d = STATUS_OK;
    exec_data_d   = 8'h00;
    if ((cmd_q ^ arg_q) != chk_q) begin
      exec_status_d = STATUS_BAD_CHK;
    end else begin
      case (cmd_q)
        CMD_WRITE_LED: exec_data_d = arg_q;
        CMD_READ_LED:  exec_data_d = 8'(led_q);
        CMD_PING:      exec_data_d = arg_q;
`ifdef CMD_STATS_EN
        CMD_READ_STATS: begin
          if (arg_q == 8'h00)      exec_data_d = good_cnt_q;
          else if (arg_q == 8'h01) exec_data_d = err_cnt_q;
          else begin
            exec_status_d = STATUS_BAD_CMD;
            exec_data_d   = arg_q;
          end
        end
`endif
        default: begin
          exec_status_d = STATUS_BAD_CMD;
          exec_data_d   = cmd_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      arg_q        <= 8'h00;
      chk_q        <= 8'h00;
      rsp_status_q <= STATUS_OK;
      rsp_data_q   <= 8'h00;
      idx_q        <= 2'd0;
      led_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      tmo_q        <= '0;
      tmo_err_q    <= 1'b0;
    end else begin
      tmo_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_REQ) begin
            state_q <= ST_GET_CMD;
            tmo_q   <= '0;
          end
        end
        ST_GET_CMD, ST_GET_ARG, ST_GET_CHK: begin
          // A byte on the expiry cycle wins over the timeout abort.
          if (rx_valid) begin
            tmo_q <= '0;
            case (state_q)
              ST_GET_CMD: begin cmd_q <= rx_data; state_q <= ST_GET_ARG; end
              ST_GET_ARG: begin arg_q <= rx_data; state_q <= ST_GET_CHK; end
              default:    begin chk_q <= rx_data; state_q <= ST_EXEC;    end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            tmo_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_EXEC: begin
          rsp_status_q <= exec_status_d;
          rsp_data_q   <= exec_data_d;
          if (cmd_q == CMD_WRITE_LED && exec_status_d == STATUS_OK)
            led_q <= arg_q[LED_W-1:0];
          tx_data_q  <= SYNC_RSP;
          tx_valid_q <= 1'b1;
          idx_q      <= 2'd0;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_q <= rsp_byte(idx_q + 2'd1, rsp_status_q, rsp_data_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CMD_STATS_EN
  // Counters update at the end of EXEC, so READ_STATS sees the pre-packet value.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt_q <= 8'h00;
      err_cnt_q  <= 8'h00;
    end else begin
      if (state_q == ST_EXEC && exec_status_d == STATUS_OK && good_cnt_q != 8'hFF)
        good_cnt_q <= good_cnt_q + 8'd1;
      if (((state_q == ST_EXEC && exec_status_d != STATUS_OK) || tmo_err_q) &&
          err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign led       = led_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_pulse = tmo_err_q | (state_q == ST_EXEC && exec_status_d != STATUS_OK);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: expected response bytes are queued
// when a request is driven and compared as the transmitter accepts each byte.
module tb_uart_cmd_responder;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [5:0] led;
  logic       busy;
  logic       err_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  uart_cmd_responder #(.TIMEOUT_CYCLES(TMO), .LED_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .led      (led),
    .busy     (busy),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Accepted TX bytes are popped and compared; an unexpected byte is a failure.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_spurious", 32'(exp_q.size()), 32'd1);
      else                   check("tx_byte", tx_data, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Returns one cycle after the CHK strobe, i.e. during EXEC.
  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(arg);
    send_byte(chk);
  endtask

  task automatic push_rsp(input logic [7:0] st, input logic [7:0] dt);
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(dt);
    exp_q.push_back(st ^ dt);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_led", led, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_err", err_pulse, 0);

    // Non-sync bytes in IDLE are discarded.
    send_byte(8'h00);
    send_byte(8'h5A);
    check("idle_junk_busy", busy, 0);

    // WRITE_LED 0x2A with latency checks.
    push_rsp(8'h00, 8'h2A);
    send_pkt(8'h01, 8'h2A, 8'h2B);
    check("wr_exec_led_old", led, 6'h00);
    check("wr_exec_busy", busy, 1);
    check("wr_exec_err", err_pulse, 0);
    @(posedge clk); #1;
    check("wr_led_new", led, 6'h2A);
    check("wr_first_byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h5A});
    drain("wr");

    // Set 0x15, then READ_LED.
    push_rsp(8'h00, 8'h15);
    send_pkt(8'h01, 8'h15, 8'h14);
    drain("wr15");
    push_rsp(8'h00, 8'h15);
    send_pkt(8'h02, 8'h00, 8'h02);
    drain("rd");
    check("rd_led", led, 6'h15);

    // Bad checksum: no LED write, one-cycle error pulse.
    push_rsp(8'h01, 8'h00);
    send_pkt(8'h01, 8'h3F, 8'h00);
    check("badchk_err", err_pulse, 1);
    @(posedge clk); #1;
    check("badchk_err_end", err_pulse, 0);
    drain("badchk");
    check("badchk_led", led, 6'h15);

    // Unknown command with a stalled transmitter and a stray RX byte.
    tx_ready = 1'b0;
    push_rsp(8'h02, 8'h07);
    send_pkt(8'h07, 8'h00, 8'h07);
    check("badcmd_err", err_pulse, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rx_valid = (i == 3);
      rx_data  = (i == 3) ? 8'hA5 : 8'h00;
      check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h5A});
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    drain("badcmd");

    // 0xA5 inside a packet is data, not a resync.
    push_rsp(8'h00, 8'hA5);
    send_pkt(8'h01, 8'hA5, 8'hA4);
    drain("a5data");
    check("a5data_led", led, 6'h25);

    // Timeout after A5 03: abort exactly TMO cycles after the last strobe.
    send_byte(8'hA5);
    send_byte(8'h03);
    n = 0;
    while (!err_pulse && n < TMO + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1 check("tmo_no_tx", tx_valid, 0);

    push_rsp(8'h00, 8'hC3);
    send_pkt(8'h03, 8'hC3, 8'hC0);
    drain("ping");

`ifdef CMD_STATS_EN
    push_rsp(8'h00, 8'h03);
`else
    push_rsp(8'h02, 8'h04);
`endif
    send_pkt(8'h04, 8'h01, 8'h05);
    drain("stats");

    // Reset in the middle of SEND aborts the response.
    tx_ready = 1'b0;
    send_pkt(8'h03, 8'h11, 8'h12);
    @(posedge clk); #1;
    check("midsend_txv", tx_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_txv", tx_valid, 0);
    check("rst2_led", led, 6'h00);
    check("rst2_busy", busy, 0);
    tx_ready = 1'b1;
    push_rsp(8'h00, 8'h00);
    send_pkt(8'h02, 8'h00, 8'h02);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
